// File: rtl/hazard_detection_unit.sv
// Hazard detection unit: ID-stage stall (RAW / load-use) and whole-pipeline memory freeze.
// Latency: hazard/freeze are combinational from inputs and state; mem_error and counters update on clk.
// Backpressure: freeze dominates hazard; after TIMEOUT wait cycles the unit latches mem_error and freezes until reset.
//
// Ports:
//   clk, rst (async active-low)
//   forward_en, id_valid, src_1, src_2, two_src          : ID-stage operand info
//   EXE_dest, EXE_wb_en, EXE_mem_r_en                    : EXE-stage producer
//   MEM_dest, MEM_wb_en, MEM_mem_access, mem_ready       : MEM-stage producer / data memory handshake
//   hazard, freeze, mem_error, stall_cnt, freeze_cnt     : controls, sticky error, debug counters
module hazard_detection_unit #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic             id_valid,
    input  logic [3:0]       src_1,
    input  logic [3:0]       src_2,
    input  logic             two_src,
    input  logic [3:0]       EXE_dest,
    input  logic             EXE_wb_en,
    input  logic             EXE_mem_r_en,
    input  logic [3:0]       MEM_dest,
    input  logic             MEM_wb_en,
    input  logic             MEM_mem_access,
    input  logic             mem_ready,
    output logic             hazard,
    output logic             freeze,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    localparam logic [7:0]       LP_TIMEOUT = 8'(TIMEOUT);
    localparam logic [7:0]       LP_WAIT_1  = 8'd1;
    localparam logic [CNT_W-1:0] LP_CNT_1   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;

    state_t           r_state;
    logic [7:0]       r_wait;
    logic             r_mem_error;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    logic w_exe_match;
    logic w_mem_match;
    logic w_raw_hazard;
    logic w_freeze_st;
    logic w_freeze;
    logic w_hazard;

    // Operand match: src_2 only counts when the instruction actually reads it.
    assign w_exe_match = (EXE_dest == src_1) | (two_src & (EXE_dest == src_2));
    assign w_mem_match = (MEM_dest == src_1) | (two_src & (MEM_dest == src_2));

    // With forwarding only a load in EXE cannot be bypassed in time (load-use).
    always_comb begin
        w_raw_hazard = 1'b0;
        if (id_valid) begin
            if (forward_en) begin
                w_raw_hazard = EXE_mem_r_en & EXE_wb_en & w_exe_match;
            end else begin
                w_raw_hazard = (EXE_wb_en & w_exe_match) | (MEM_wb_en & w_mem_match);
            end
        end
    end

    always_comb begin
        w_freeze_st = 1'b0;
        case (r_state)
            ST_RUN:    w_freeze_st = MEM_mem_access & ~mem_ready;
            ST_FREEZE: w_freeze_st = ~mem_ready;
            ST_ERROR:  w_freeze_st = 1'b1;
            default:   w_freeze_st = 1'b1;
        endcase
    end

    // Both controls are forced low while reset is held, independent of inputs.
    assign w_freeze = rst & w_freeze_st;
    assign w_hazard = rst & w_raw_hazard & ~w_freeze;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_RUN;
            r_wait       <= '0;
            r_mem_error  <= 1'b0;
            r_stall_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A ready in the same cycle as the access is a single-cycle access.
                    if (MEM_mem_access && !mem_ready) begin
                        r_state <= ST_FREEZE;
                        r_wait  <= LP_WAIT_1;
                    end
                end
                ST_FREEZE: begin
                    if (mem_ready) begin
                        r_state <= ST_RUN;
                        r_wait  <= '0;
                    end else if (r_wait < LP_TIMEOUT) begin
                        r_wait <= r_wait + LP_WAIT_1;
                    end else begin
                        r_state     <= ST_ERROR;
                        r_mem_error <= 1'b1;
                    end
                end
                ST_ERROR: begin
                    r_mem_error <= 1'b1;
                end
                default: begin
                    r_state <= ST_ERROR;
                    r_mem_error <= 1'b1;
                end
            endcase

            if (w_hazard && (r_stall_cnt != LP_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + LP_CNT_1;
            end
            if (w_freeze && (r_freeze_cnt != LP_CNT_MAX)) begin
                r_freeze_cnt <= r_freeze_cnt + LP_CNT_1;
            end
        end
    end

    assign hazard     = w_hazard;
    assign freeze     = w_freeze;
    assign mem_error  = r_mem_error;
    assign stall_cnt  = r_stall_cnt;
    assign freeze_cnt = r_freeze_cnt;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Bench for hazard_detection_unit: default instance plus a CNT_W=4 instance on shared inputs.
// Expected outputs come from a behavioural model, queued when stimulus is applied and checked mid-cycle.
// Runs a fixed number of cycles; no open-ended waits.
module tb_hazard_detection_unit;

    logic       clk;
    logic       rst;
    logic       forward_en, id_valid, two_src;
    logic [3:0] src_1, src_2, EXE_dest, MEM_dest;
    logic       EXE_wb_en, EXE_mem_r_en, MEM_wb_en, MEM_mem_access, mem_ready;

    logic        hazard, freeze, mem_error;
    logic [15:0] stall_cnt, freeze_cnt;
    logic        hazard4, freeze4, mem_error4;
    logic [3:0]  stall_cnt4, freeze_cnt4;

    hazard_detection_unit #(.TIMEOUT(15), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .src_1(src_1), .src_2(src_2), .two_src(two_src),
        .EXE_dest(EXE_dest), .EXE_wb_en(EXE_wb_en), .EXE_mem_r_en(EXE_mem_r_en),
        .MEM_dest(MEM_dest), .MEM_wb_en(MEM_wb_en), .MEM_mem_access(MEM_mem_access),
        .mem_ready(mem_ready), .hazard(hazard), .freeze(freeze), .mem_error(mem_error),
        .stall_cnt(stall_cnt), .freeze_cnt(freeze_cnt)
    );

    hazard_detection_unit #(.TIMEOUT(15), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .forward_en(forward_en), .id_valid(id_valid),
        .src_1(src_1), .src_2(src_2), .two_src(two_src),
        .EXE_dest(EXE_dest), .EXE_wb_en(EXE_wb_en), .EXE_mem_r_en(EXE_mem_r_en),
        .MEM_dest(MEM_dest), .MEM_wb_en(MEM_wb_en), .MEM_mem_access(MEM_mem_access),
        .mem_ready(mem_ready), .hazard(hazard4), .freeze(freeze4), .mem_error(mem_error4),
        .stall_cnt(stall_cnt4), .freeze_cnt(freeze_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        haz;
        logic        frz;
        logic        err;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [3:0]  sc4;
        logic [3:0]  fc4;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state (0 RUN, 1 FREEZE, 2 ERROR).
    int          m_state;
    int          m_wait;
    logic        m_err;
    logic [15:0] m_sc, m_fc;
    logic [3:0]  m_sc4, m_fc4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_wait  = 0;
        m_err   = 1'b0;
        m_sc    = '0;
        m_fc    = '0;
        m_sc4   = '0;
        m_fc4   = '0;
    endtask

    task automatic model_comb(output logic haz, output logic frz);
        logic me, mm, raw;
        me = (EXE_dest == src_1) || (two_src && (EXE_dest == src_2));
        mm = (MEM_dest == src_1) || (two_src && (MEM_dest == src_2));
        if (!id_valid)       raw = 1'b0;
        else if (forward_en) raw = EXE_mem_r_en && EXE_wb_en && me;
        else                 raw = (EXE_wb_en && me) || (MEM_wb_en && mm);
        if (m_state == 0)      frz = MEM_mem_access && !mem_ready;
        else if (m_state == 1) frz = !mem_ready;
        else                   frz = 1'b1;
        if (!rst) frz = 1'b0;
        haz = rst && raw && !frz;
    endtask

    task automatic model_edge();
        logic haz, frz;
        if (!rst) begin
            model_reset();
            return;
        end
        model_comb(haz, frz);
        if (haz) begin
            if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (m_sc4 != 4'hF)    m_sc4 = m_sc4 + 4'd1;
        end
        if (frz) begin
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            if (m_fc4 != 4'hF)    m_fc4 = m_fc4 + 4'd1;
        end
        case (m_state)
            0: if (MEM_mem_access && !mem_ready) begin m_state = 1; m_wait = 1; end
            1: begin
                if (mem_ready)          begin m_state = 0; m_wait = 0; end
                else if (m_wait < 15)   m_wait = m_wait + 1;
                else                    begin m_state = 2; m_err = 1'b1; end
            end
            default: m_err = 1'b1;
        endcase
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        logic haz, frz;
        model_comb(haz, frz);
        e.tag = tag; e.haz = haz; e.frz = frz; e.err = m_err;
        e.sc = m_sc; e.fc = m_fc; e.sc4 = m_sc4; e.fc4 = m_fc4;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        chk({e.tag, ".hazard"},      {31'd0, hazard},     {31'd0, e.haz});
        chk({e.tag, ".freeze"},      {31'd0, freeze},     {31'd0, e.frz});
        chk({e.tag, ".mem_error"},   {31'd0, mem_error},  {31'd0, e.err});
        chk({e.tag, ".stall_cnt"},   {16'd0, stall_cnt},  {16'd0, e.sc});
        chk({e.tag, ".freeze_cnt"},  {16'd0, freeze_cnt}, {16'd0, e.fc});
        chk({e.tag, ".hazard4"},     {31'd0, hazard4},    {31'd0, e.haz});
        chk({e.tag, ".freeze4"},     {31'd0, freeze4},    {31'd0, e.frz});
        chk({e.tag, ".stall_cnt4"},  {28'd0, stall_cnt4}, {28'd0, e.sc4});
        chk({e.tag, ".freeze_cnt4"}, {28'd0, freeze_cnt4},{28'd0, e.fc4});
    endtask

    // One cycle: inputs already applied by caller; check at negedge, advance model at posedge.
    task automatic step(input string tag);
        #1;
        push_exp(tag);
        @(negedge clk);
        pop_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        forward_en = 1'b1; id_valid = 1'b0; two_src = 1'b0;
        src_1 = 4'd0; src_2 = 4'd0; EXE_dest = 4'd15; MEM_dest = 4'd14;
        EXE_wb_en = 1'b0; EXE_mem_r_en = 1'b0; MEM_wb_en = 1'b0;
        MEM_mem_access = 1'b0; mem_ready = 1'b1;
    endtask

    task automatic load_use();
        forward_en = 1'b1; id_valid = 1'b1; src_1 = 4'd3;
        EXE_dest = 4'd3; EXE_wb_en = 1'b1; EXE_mem_r_en = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        model_reset();
        // Reset state, with a pending access and a load-use to show both controls are masked.
        MEM_mem_access = 1'b1; mem_ready = 1'b0; load_use();
        #2;
        push_exp("reset");
        pop_check();
        idle_inputs();
        #5 rst = 1'b1;

        // Load-use hazard.
        load_use();
        step("load_use");
        idle_inputs();
        step("after_load_use");
        chk("stall_cnt_one", {16'd0, stall_cnt}, 32'd1);

        // MEM-stage match on src_2.
        id_valid = 1'b1; MEM_wb_en = 1'b1; MEM_dest = 4'd5; src_2 = 4'd5; two_src = 1'b1;
        src_1 = 4'd9;
        step("mem_fwd");
        chk("mem_fwd_no_hazard", {31'd0, hazard}, 32'd0);
        forward_en = 1'b0;
        step("mem_nofwd");
        two_src = 1'b0;
        step("mem_nofwd_one_src");
        two_src = 1'b1; id_valid = 1'b0;
        step("mem_nofwd_invalid");
        // No-forwarding EXE match, and register 0 treated like any other index.
        id_valid = 1'b1; MEM_wb_en = 1'b0; EXE_wb_en = 1'b1; EXE_dest = 4'd0; src_1 = 4'd0;
        step("exe_nofwd_r0");
        idle_inputs();

        // Memory wait of 4 cycles with a load-use masked underneath.
        load_use();
        MEM_mem_access = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) step("freeze4");
        mem_ready = 1'b1;
        step("freeze_release");
        MEM_mem_access = 1'b0;
        idle_inputs();
        step("after_freeze");

        // Single-cycle access: ready with the request.
        MEM_mem_access = 1'b1; mem_ready = 1'b1;
        step("single_cycle");
        idle_inputs();

        // Random mixed traffic.
        for (int i = 0; i < 150; i++) begin
            forward_en     = 1'($urandom_range(0, 1));
            id_valid       = ($urandom_range(0, 3) != 0);
            two_src        = 1'($urandom_range(0, 1));
            src_1          = 4'($urandom_range(0, 3));
            src_2          = 4'($urandom_range(0, 3));
            EXE_dest       = 4'($urandom_range(0, 3));
            MEM_dest       = 4'($urandom_range(0, 3));
            EXE_wb_en      = 1'($urandom_range(0, 1));
            EXE_mem_r_en   = 1'($urandom_range(0, 1));
            MEM_wb_en      = 1'($urandom_range(0, 1));
            MEM_mem_access = ($urandom_range(0, 9) < 3);
            mem_ready      = ($urandom_range(0, 3) != 0);
            step("random");
        end
        idle_inputs();

        // Saturation of the narrow stall counter.
        load_use();
        for (int i = 0; i < 20; i++) step("stall_sat");
        chk("stall_cnt4_sat", {28'd0, stall_cnt4}, 32'd15);
        idle_inputs();

        // Timeout into ERROR.
        MEM_mem_access = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 17; i++) step("timeout");
        chk("mem_error_set", {31'd0, mem_error}, 32'd1);
        mem_ready = 1'b1; MEM_mem_access = 1'b0;
        step("error_hold");
        chk("error_freeze_hold", {31'd0, freeze}, 32'd1);

        // Reset clears ERROR.
        rst = 1'b0;
        #1;
        model_reset();
        push_exp("rst_error");
        pop_check();
        #2 rst = 1'b1;
        step("after_rst_error");

        // Asynchronous reset in the middle of a FREEZE window.
        MEM_mem_access = 1'b1; mem_ready = 1'b0;
        step("pre_async");
        step("pre_async");
        rst = 1'b0;
        #1;
        model_reset();
        push_exp("async_rst");
        pop_check();
        step("async_rst_held");
        rst = 1'b1;
        idle_inputs();
        step("post_async");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
Producer-side counterpart of the EXE-stage forwarding logic. It decides when the ID stage must stall because a source operand cannot be supplied by forwarding, and when the whole pipeline must freeze while the data memory is busy. It sits beside the ID stage and drives the IF/ID stall and ID/EXE bubble controls. It also tracks memory-wait timeouts and keeps saturating stall/freeze counters for debug.

Parameters:
TIMEOUT, 15, max consecutive FREEZE cycles before declaring a memory error (1..255)
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset; asynchronous, active-low
forward_en  input  1  forwarding enabled in EXE
id_valid  input  1  ID stage holds a real instruction
src_1  input  4  ID source register 1
src_2  input  4  ID source register 2
two_src  input  1  instruction reads src_2
EXE_dest  input  4  destination register of the EXE-stage instruction
EXE_wb_en  input  1  EXE-stage instruction writes back
EXE_mem_r_en  input  1  EXE-stage instruction is a load
MEM_dest  input  4  destination register of the MEM-stage instruction
MEM_wb_en  input  1  MEM-stage instruction writes back
MEM_mem_access  input  1  MEM stage has a load or store in flight
mem_ready  input  1  data memory completes the access this cycle
hazard  output  1  stall PC and IF/ID; insert bubble into ID/EXE
freeze  output  1  hold all pipeline registers
mem_error  output  1  sticky memory-timeout flag
stall_cnt  output  CNT_W  cycles with hazard=1
freeze_cnt  output  CNT_W  cycles with freeze=1

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, wait counter=0, mem_error=0, stall_cnt=0, freeze_cnt=0.
  - hazard=0 and freeze=0 while reset is asserted.
- Operand match:
  - m1(d) = (d==src_1).
  - m2(d) = two_src & (d==src_2).
  - match(d) = m1(d) | m2(d).
- raw_hazard is combinational and is 0 when id_valid=0.
  - forward_en=0: raw_hazard = (EXE_wb_en & match(EXE_dest)) | (MEM_wb_en & match(MEM_dest)).
  - forward_en=1: raw_hazard = EXE_mem_r_en & EXE_wb_en & match(EXE_dest). This is the load-use case only; MEM matches are forwarded.
- freeze is combinational:
  - RUN: freeze = MEM_mem_access & ~mem_ready.
  - FREEZE: freeze = ~mem_ready.
  - ERROR: freeze = 1.
- hazard = raw_hazard & ~freeze. A freeze dominates, so the pipeline is never stalled and bubbled simultaneously.
- FSM transitions, evaluated on the clk rising edge:
  - RUN -> FREEZE when MEM_mem_access & ~mem_ready; wait counter <= 1.
  - FREEZE -> RUN when mem_ready; wait counter <= 0.
  - FREEZE stays in FREEZE when ~mem_ready and wait counter < TIMEOUT; wait counter increments.
  - FREEZE -> ERROR when ~mem_ready and wait counter == TIMEOUT; mem_error <= 1.
  - ERROR is terminal until reset. mem_error stays 1 and freeze stays 1 regardless of mem_ready.
- mem_ready in the same cycle as a new access in RUN is a single-cycle access: no freeze, state stays RUN.
- Counters:
  - stall_cnt increments on every edge where hazard=1.
  - freeze_cnt increments on every edge where freeze=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Register 0 gets no special treatment; matching is purely by 4-bit index.
- Reset mid-FREEZE or in ERROR returns to RUN immediately and clears all flags and counters.

Test Plan:
- forward_en=1, id_valid=1, EXE_mem_r_en=1, EXE_wb_en=1, EXE_dest=3, src_1=3 -> hazard=1, freeze=0; stall_cnt=1 after one edge.
- forward_en=1, MEM_wb_en=1, MEM_dest=5, src_2=5, two_src=1, no EXE load -> hazard=0. Same with forward_en=0 -> hazard=1. Same with two_src=0 -> hazard=0.
- MEM_mem_access=1, mem_ready held low 4 cycles then high -> freeze=1 for exactly 4 cycles, freeze_cnt=4, state back to RUN, mem_error=0. A load-use hazard present during this window keeps hazard=0 until freeze drops.
- mem_ready held low for TIMEOUT+1 cycles with TIMEOUT=15 -> mem_error=1 from the 16th edge on. freeze stays 1 after mem_ready rises. rst pulse clears mem_error, freeze and both counters to 0.
- CNT_W=4, hazard held high 20 cycles -> stall_cnt stops at 15.
- rst asserted mid-FREEZE asynchronously (between edges) -> freeze=0 and counters=0 before the next edge.
